// File: rtl/barcode_frame_sequencer.sv
// Frame sequencer for the digit-to-barcode converter: accepts digits over valid/ready,
// then serialises start guard, data symbols, mod-16 checksum symbol and stop guard.
module barcode_frame_sequencer #(
    parameter int         DIGITS = 4,
    parameter logic [2:0] GUARD  = 3'b101
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  din,
    input  logic        din_valid,
    output logic        din_ready,
    input  logic        abort,
    output logic [3:0]  num_out,
    input  logic [10:0] bc_in,
    output logic        bar_out,
    output logic        bar_valid,
    output logic        frame_done,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE,
        GUARD_S,
        FETCH,
        SHIFT,
        LOAD,
        GUARD_E
    } state_t;

    localparam logic [3:0] LAST_DIGIT = 4'(DIGITS);

    state_t      state;
    state_t      state_next;
    logic [3:0]  digit_reg;
    logic [3:0]  digit_next;
    logic [3:0]  csum;
    logic [3:0]  csum_next;
    logic [3:0]  cnt;
    logic [3:0]  cnt_next;
    logic [3:0]  bit_idx;
    logic [3:0]  bit_idx_next;
    logic [10:0] sreg;
    logic [10:0] sreg_next;
    logic        chk;
    logic        chk_next;
    logic        accept;
    logic        bar_out_d;
    logic        bar_valid_d;
    logic        frame_done_d;
    logic        busy_d;

    // Abort blocks the handshake so a digit can never be consumed by a frame that is being dropped
    assign din_ready = rst_n && !abort && ((state == IDLE) || (state == LOAD));
    assign accept    = din_valid && din_ready;
    assign num_out   = digit_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            digit_reg  <= '0;
            csum       <= '0;
            cnt        <= '0;
            bit_idx    <= '0;
            sreg       <= '0;
            chk        <= 1'b0;
            bar_out    <= 1'b0;
            bar_valid  <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_next;
            digit_reg  <= digit_next;
            csum       <= csum_next;
            cnt        <= cnt_next;
            bit_idx    <= bit_idx_next;
            sreg       <= sreg_next;
            chk        <= chk_next;
            bar_out    <= bar_out_d;
            bar_valid  <= bar_valid_d;
            frame_done <= frame_done_d;
            busy       <= busy_d;
        end
    end

    always_comb begin
        state_next   = state;
        digit_next   = digit_reg;
        csum_next    = csum;
        cnt_next     = cnt;
        bit_idx_next = bit_idx;
        sreg_next    = sreg;
        chk_next     = chk;
        if (abort) begin
            state_next = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        digit_next   = din;
                        csum_next    = din;
                        cnt_next     = 4'd1;
                        bit_idx_next = '0;
                        chk_next     = 1'b0;
                        state_next   = GUARD_S;
                    end
                end
                GUARD_S, GUARD_E: begin
                    if (bit_idx == 4'd2) begin
                        bit_idx_next = '0;
                        state_next   = (state == GUARD_S) ? FETCH : IDLE;
                    end else begin
                        bit_idx_next = bit_idx + 4'd1;
                    end
                end
                FETCH: begin
                    sreg_next    = bc_in;
                    bit_idx_next = '0;
                    state_next   = SHIFT;
                end
                SHIFT: begin
                    sreg_next    = {sreg[9:0], 1'b0};
                    bit_idx_next = bit_idx + 4'd1;
                    if (bit_idx == 4'd10) begin
                        bit_idx_next = '0;
                        if (chk) begin
                            state_next = GUARD_E;
                        end else if (cnt < LAST_DIGIT) begin
                            state_next = LOAD;
                        end else begin
                            // Last data symbol sent: reuse the converter for the checksum symbol
                            digit_next = csum;
                            chk_next   = 1'b1;
                            state_next = FETCH;
                        end
                    end
                end
                LOAD: begin
                    if (accept) begin
                        digit_next = din;
                        csum_next  = csum + din;
                        cnt_next   = cnt + 4'd1;
                        state_next = FETCH;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Outputs are computed for the state being entered so the registered values line up with it
    always_comb begin
        bar_valid_d  = (state_next == GUARD_S) || (state_next == SHIFT) || (state_next == GUARD_E);
        bar_out_d    = 1'b0;
        if (state_next == SHIFT) begin
            bar_out_d = sreg_next[10];
        end else if ((state_next == GUARD_S) || (state_next == GUARD_E)) begin
            bar_out_d = GUARD[2'd2 - bit_idx_next[1:0]];
        end
        frame_done_d = (state == GUARD_E) && (bit_idx == 4'd2) && !abort;
        busy_d       = (state_next != IDLE);
    end

endmodule

// File: tb/tb_barcode_frame_sequencer.sv
// Directed bench for barcode_frame_sequencer: drives whole frames and checks the serial stream,
// handshake stalls, checksum wrap, abort and mid-frame reset against hand-computed values.
module tb_barcode_frame_sequencer;

    localparam logic [2:0] GUARD = 3'b101;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  din;
    logic        din_valid;
    logic        din_ready;
    logic        abort;
    logic [3:0]  num_out;
    logic [10:0] bc_in;
    logic        bar_out;
    logic        bar_valid;
    logic        frame_done;
    logic        busy;

    int   checks = 0;
    int   errors = 0;
    logic bits_q[$];

    always #5 clk = ~clk;

    // Reference converter: distinct asymmetric 11-module patterns so bit order errors show up
    function automatic logic [10:0] bc_ref(input logic [3:0] d);
        case (d)
            4'd0:    return 11'b11011001100;
            4'd1:    return 11'b11001101100;
            4'd2:    return 11'b11001100110;
            4'd3:    return 11'b10010011000;
            4'd4:    return 11'b10010001100;
            4'd5:    return 11'b10001001100;
            4'd6:    return 11'b10011001000;
            4'd7:    return 11'b10011000100;
            4'd8:    return 11'b10001100100;
            4'd9:    return 11'b11001001000;
            4'd10:   return 11'b11001000100;
            4'd11:   return 11'b11000100100;
            4'd12:   return 11'b10110011100;
            4'd13:   return 11'b10011011100;
            4'd14:   return 11'b10011001110;
            default: return 11'b10111001100;
        endcase
    endfunction

    assign bc_in = bc_ref(num_out);

    barcode_frame_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .abort      (abort),
        .num_out    (num_out),
        .bc_in      (bc_in),
        .bar_out    (bar_out),
        .bar_valid  (bar_valid),
        .frame_done (frame_done),
        .busy       (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [3:0] d, input logic ab);
        din_valid = v;
        din       = d;
        abort     = ab;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Runs one frame; optional stall before the third digit, abort or reset at a given cycle
    task automatic run_frame(input string tag, input logic [3:0] d0, input logic [3:0] d1,
                             input logic [3:0] d2, input logic [3:0] d3, input logic [3:0] exp_csum,
                             input int stall_len, input int abort_cyc, input int reset_cyc,
                             input int exp_done);
        logic [3:0]  digs [4];
        logic [10:0] syms [5];
        logic [60:0] got_s;
        int          idx;
        int          cyc;
        int          done_cyc;
        int          stall_n;
        logic        hs;
        logic        done;
        logic        interrupted;

        digs        = '{d0, d1, d2, d3};
        syms        = '{bc_ref(d0), bc_ref(d1), bc_ref(d2), bc_ref(d3), bc_ref(exp_csum)};
        bits_q.delete();
        idx         = 0;
        cyc         = 0;
        done_cyc    = 0;
        stall_n     = 0;
        done        = 1'b0;
        interrupted = 1'b0;
        applyStimulus(1'b1, digs[0], 1'b0);

        while (!done && !interrupted && cyc < 300) begin
            #1;
            hs = din_valid && din_ready;
            tick();
            cyc++;
            if (hs) begin
                idx++;
                if (idx >= 4) begin
                    din_valid = 1'b0;
                end else begin
                    din = digs[idx];
                    if (idx == 2 && stall_len > 0) din_valid = 1'b0;
                end
            end
            if (bar_valid) bits_q.push_back(bar_out);
            if (frame_done) begin
                done     = 1'b1;
                done_cyc = cyc;
            end
            if (cyc == 1) begin
                checkOutput({tag, "_busy_c1"}, busy, 1);
                checkOutput({tag, "_ready_c1"}, din_ready, 0);
            end
            if (idx == 2 && stall_len > 0 && !din_valid) begin
                if (stall_n < stall_len && (stall_n > 0 || din_ready)) begin
                    checkOutput($sformatf("%s_stall_ready%0d", tag, stall_n), din_ready, 1);
                    checkOutput($sformatf("%s_stall_valid%0d", tag, stall_n), bar_valid, 0);
                    stall_n++;
                end else if (stall_n == stall_len) begin
                    din_valid = 1'b1;
                end
            end
            if (abort_cyc > 0 && cyc == abort_cyc) begin
                applyStimulus(1'b0, 4'd0, 1'b1);
                tick();
                applyStimulus(1'b0, 4'd0, 1'b0);
                #1;
                checkOutput({tag, "_busy"}, busy, 0);
                checkOutput({tag, "_bar_valid"}, bar_valid, 0);
                checkOutput({tag, "_ready"}, din_ready, 1);
                checkOutput({tag, "_no_done"}, frame_done, 0);
                checkOutput({tag, "_bits_before"}, bits_q.size(), 17);
                interrupted = 1'b1;
            end
            if (reset_cyc > 0 && cyc == reset_cyc) begin
                rst_n     = 1'b0;
                din_valid = 1'b0;
                tick();
                rst_n = 1'b1;
                #1;
                checkOutput({tag, "_bar_out"}, bar_out, 0);
                checkOutput({tag, "_bar_valid"}, bar_valid, 0);
                checkOutput({tag, "_frame_done"}, frame_done, 0);
                checkOutput({tag, "_busy"}, busy, 0);
                checkOutput({tag, "_num_out"}, num_out, 0);
                checkOutput({tag, "_ready"}, din_ready, 1);
                interrupted = 1'b1;
            end
        end

        if (!interrupted) begin
            checkOutput({tag, "_done_seen"}, done, 1);
            checkOutput({tag, "_done_cycle"}, done_cyc, exp_done);
            checkOutput({tag, "_bit_count"}, bits_q.size(), 61);
            got_s = '0;
            for (int k = 0; k < 61 && k < bits_q.size(); k++) got_s[60-k] = bits_q[k];
            checkOutput({tag, "_guard_start"}, got_s[60:58], GUARD);
            for (int i = 0; i < 5; i++)
                checkOutput($sformatf("%s_sym%0d", tag, i), got_s[57-11*i -: 11], syms[i]);
            checkOutput({tag, "_guard_end"}, got_s[2:0], GUARD);
            tick();
            checkOutput({tag, "_done_one_cycle"}, frame_done, 0);
            checkOutput({tag, "_idle_busy"}, busy, 0);
        end
    endtask

    initial begin
        applyStimulus(1'b0, 4'd0, 1'b0);
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        $display("[TB] reset state");
        checkOutput("rst_bar_out", bar_out, 0);
        checkOutput("rst_bar_valid", bar_valid, 0);
        checkOutput("rst_frame_done", frame_done, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_num_out", num_out, 0);
        checkOutput("rst_ready", din_ready, 1);
        tick();

        $display("[TB] basic, stalled and wrapping frames");
        run_frame("basic", 4'd0, 4'd5, 4'd10, 4'd15, 4'd14, 0, 0, 0, 70);
        run_frame("stall", 4'd0, 4'd5, 4'd10, 4'd15, 4'd14, 7, 0, 0, 77);
        run_frame("wrap", 4'd15, 4'd15, 4'd15, 4'd15, 4'd12, 0, 0, 0, 70);

        $display("[TB] abort and mid-frame reset");
        run_frame("abort", 4'd3, 4'd9, 4'd6, 4'd1, 4'd3, 0, 20, 0, 0);
        run_frame("post_abort", 4'd2, 4'd7, 4'd11, 4'd4, 4'd8, 0, 0, 0, 70);
        run_frame("reset", 4'd1, 4'd2, 4'd3, 4'd4, 4'd10, 0, 0, 60, 0);
        run_frame("post_reset", 4'd9, 4'd8, 4'd7, 4'd6, 4'd14, 0, 0, 0, 70);

        $display("[TB] abort colliding with a digit in IDLE");
        applyStimulus(1'b1, 4'd7, 1'b1);
        #1;
        checkOutput("coll_ready", din_ready, 0);
        tick();
        checkOutput("coll_busy", busy, 0);
        checkOutput("coll_bar_valid", bar_valid, 0);
        abort = 1'b0;
        #1;
        checkOutput("coll_ready_after", din_ready, 1);
        run_frame("coll_frame", 4'd7, 4'd1, 4'd2, 4'd3, 4'd13, 0, 0, 0, 70);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
